// File: rtl/rgb_seq_ctrl.sv
// ============================================================================
// Module   : rgb_seq_ctrl
// Brief    : Steps a 4-entry {a,b} code table into the RGB colour decoder,
//            holding each code for a programmable dwell. Optional macro
//            RGB_SEQ_LOAD_EN makes the table writable through ld_*.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_seq_ctrl #(
    parameter int          DWELL_W         = 8,
    parameter logic [15:0] DEFAULT_PATTERN = 16'h1B4E,
    parameter logic [3:0]  IDLE_CODE       = 4'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               one_shot,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               ld_we,
    input  logic [1:0]         ld_addr,
    input  logic [3:0]         ld_data,
    output logic [1:0]         a_out,
    output logic [1:0]         b_out,
    output logic               step_pulse,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic [1:0]         w_idx_inc;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [DWELL_W-1:0] w_reload;
    logic [3:0]         r_ab;
    logic [3:0]         w_ab_nxt;
    logic               r_step;
    logic               w_step_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_restart;
    logic               w_active;
    logic [3:0][3:0]    w_table;

`ifdef RGB_SEQ_LOAD_EN
    logic [3:0][3:0]    r_table;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_table <= DEFAULT_PATTERN;
        end else if (ld_we) begin
            r_table[ld_addr] <= ld_data;
        end
    end

    assign w_table = r_table;
`else
    logic w_unused_ld;

    assign w_table     = DEFAULT_PATTERN;
    assign w_unused_ld = ^{ld_we, ld_addr, ld_data};
`endif

    // A dwell of zero behaves as a one-cycle step.
    assign w_reload  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign w_idx_inc = r_idx + 2'd1;
    assign w_restart = start && !stop;
    assign w_active  = (r_state == c_st_run) || (r_state == c_st_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_restart) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run, c_st_hold: begin
                if (stop) begin
                    w_state_nxt = c_st_idle;
                end else if (start) begin
                    w_state_nxt = c_st_run;
                end else if (pause) begin
                    w_state_nxt = c_st_hold;
                end else if ((r_cnt == '0) && (r_idx == 2'd3) && one_shot) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_state_nxt = c_st_run;
                end
            end
            default: begin
                w_state_nxt = w_restart ? c_st_run : c_st_idle;
            end
        endcase
    end

    // Any cycle with pause low advances the countdown, including the one that
    // leaves HOLD, so only the paused cycles stretch a step.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_cnt_nxt  = r_cnt;
        w_ab_nxt   = r_ab;
        w_step_nxt = 1'b0;
        if (w_restart) begin
            w_idx_nxt  = 2'd0;
            w_ab_nxt   = w_table[0];
            w_cnt_nxt  = w_reload;
            w_step_nxt = 1'b1;
        end else if ((w_state_nxt == c_st_idle) || (w_state_nxt == c_st_done)) begin
            w_idx_nxt = 2'd0;
            w_cnt_nxt = '0;
            w_ab_nxt  = IDLE_CODE;
        end else if (w_active && !pause) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - DWELL_W'(1);
            end else begin
                w_idx_nxt  = w_idx_inc;
                w_ab_nxt   = w_table[w_idx_inc];
                w_cnt_nxt  = w_reload;
                w_step_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= 2'd0;
            r_cnt  <= '0;
            r_ab   <= IDLE_CODE;
            r_step <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_cnt  <= w_cnt_nxt;
            r_ab   <= w_ab_nxt;
            r_step <= w_step_nxt;
            r_busy <= (w_state_nxt == c_st_run) || (w_state_nxt == c_st_hold);
            r_done <= (w_state_nxt == c_st_done);
        end
    end

    assign a_out      = r_ab[3:2];
    assign b_out      = r_ab[1:0];
    assign step_pulse = r_step;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire
